// File: rtl/div_pkg.sv
// Shared types and constants for the RV32M divide issue/writeback unit.
package div_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_W      = 5;
  localparam int unsigned DIV_STAGES = 8;

  localparam logic [XLEN-1:0] DIV0_QUOT = 32'hFFFF_FFFF;
  localparam logic [XLEN-1:0] OVF_QUOT  = 32'h8000_0000;
  localparam logic [XLEN-1:0] OVF_REM   = 32'h0000_0000;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  // Per-operation tag carried alongside the divider pipeline
  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_rem;
    logic             neg;
    logic             special;
    logic [XLEN-1:0]  spec_val;
  } div_tag_t;

  // Two's-complement magnitude; the most negative value maps onto itself
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x);
    return x[XLEN-1] ? XLEN'(-x) : x;
  endfunction

  // Register match where x0 is never considered a dependency
  function automatic logic rd_hit(input logic [REG_W-1:0] rd, input logic [REG_W-1:0] chk);
    return (chk != '0) && (rd == chk);
  endfunction

endpackage

// File: rtl/div_operand_prep.sv
// Issue-time operand conditioning: unsigned magnitudes, result sign and RISC-V special cases.
module div_operand_prep
  import div_pkg::*;
(
  input  div_op_e         op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] dividend,
  output logic [XLEN-1:0] divisor,
  output logic            is_rem,
  output logic            neg,
  output logic            special,
  output logic [XLEN-1:0] spec_val
);

  logic is_signed;
  logic div0;
  logic ovf;

  always_comb begin
    is_signed = (op == OP_DIV) || (op == OP_REM);
    is_rem    = (op == OP_REM) || (op == OP_REMU);
    dividend  = is_signed ? abs_val(rs1) : rs1;
    divisor   = is_signed ? abs_val(rs2) : rs2;

    div0    = (rs2 == '0);
    ovf     = is_signed && (rs1 == OVF_QUOT) && (rs2 == '1);
    special = div0 || ovf;

    spec_val = '0;
    if (div0) begin
      spec_val = is_rem ? rs1 : DIV0_QUOT;
    end else if (ovf) begin
      spec_val = is_rem ? OVF_REM : OVF_QUOT;
    end

    // Remainder takes the dividend's sign; quotient the XOR of both
    neg = 1'b0;
    if (is_signed) begin
      neg = is_rem ? rs1[XLEN-1] : (rs1[XLEN-1] ^ rs2[XLEN-1]);
    end
  end

endmodule

// File: rtl/div_issue_tracker.sv
// Divide issue/writeback tracker: shadow tag pipeline alongside the divider, sign fix-up and hazards.
// Optional operand forwarding from the final stage is enabled with `define DIV_FWD_EN.
module div_issue_tracker
  import div_pkg::*;
#(
  parameter int unsigned STAGES = DIV_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             i_valid,
  input  logic [1:0]       i_op,
  input  logic [REG_W-1:0] i_rd,
  input  logic [XLEN-1:0]  i_rs1,
  input  logic [XLEN-1:0]  i_rs2,
  output logic [XLEN-1:0]  o_div_dividend,
  output logic [XLEN-1:0]  o_div_divisor,
  input  logic [XLEN-1:0]  i_div_quotient,
  input  logic [XLEN-1:0]  i_div_remainder,
  output logic             o_wb_valid,
  output logic [REG_W-1:0] o_wb_rd,
  output logic [XLEN-1:0]  o_wb_data,
  input  logic [REG_W-1:0] i_chk_rs1,
  input  logic [REG_W-1:0] i_chk_rs2,
  output logic             o_hazard,
  output logic             o_busy
`ifdef DIV_FWD_EN
  ,
  output logic             o_fwd_hit1,
  output logic             o_fwd_hit2,
  output logic [XLEN-1:0]  o_fwd_data
`endif
);

`ifdef DIV_FWD_EN
  localparam int unsigned HZ_STAGES = STAGES - 1;
`else
  localparam int unsigned HZ_STAGES = STAGES;
`endif

  logic            prep_is_rem;
  logic            prep_neg;
  logic            prep_special;
  logic [XLEN-1:0] prep_spec_val;
  div_tag_t        issue_tag;
  div_tag_t        last;
  logic [XLEN-1:0] res;

  // Index 0 is stage 1 (youngest), index STAGES-1 feeds writeback
  div_tag_t [STAGES-1:0] tag_q;

  div_operand_prep u_prep (
    .op       (div_op_e'(i_op)),
    .rs1      (i_rs1),
    .rs2      (i_rs2),
    .dividend (o_div_dividend),
    .divisor  (o_div_divisor),
    .is_rem   (prep_is_rem),
    .neg      (prep_neg),
    .special  (prep_special),
    .spec_val (prep_spec_val)
  );

  always_comb begin
    issue_tag          = '0;
    issue_tag.valid    = i_valid && (i_rd != '0);
    issue_tag.rd       = i_rd;
    issue_tag.is_rem   = prep_is_rem;
    issue_tag.neg      = prep_neg;
    issue_tag.special  = prep_special;
    issue_tag.spec_val = prep_spec_val;
  end

  // Shadow pipeline moves in lock-step with the divider; only valid bits need reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        tag_q[k].valid <= 1'b0;
      end
    end else if (!stall) begin
      tag_q <= {tag_q[STAGES-2:0], issue_tag};
    end
  end

  always_comb begin
    last       = tag_q[STAGES-1];
    res        = last.is_rem ? i_div_remainder : i_div_quotient;
    o_wb_valid = last.valid;
    o_wb_rd    = last.rd;
    o_wb_data  = last.special ? last.spec_val : (last.neg ? XLEN'(-res) : res);
  end

  // Stages at or beyond HZ_STAGES are covered by forwarding when it is present
  always_comb begin
    o_hazard = 1'b0;
    o_busy   = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      o_busy = o_busy | tag_q[k].valid;
      if ((k < HZ_STAGES) && tag_q[k].valid &&
          (rd_hit(tag_q[k].rd, i_chk_rs1) || rd_hit(tag_q[k].rd, i_chk_rs2))) begin
        o_hazard = 1'b1;
      end
    end
  end

`ifdef DIV_FWD_EN
  always_comb begin
    o_fwd_hit1 = last.valid && rd_hit(last.rd, i_chk_rs1);
    o_fwd_hit2 = last.valid && rd_hit(last.rd, i_chk_rs2);
    o_fwd_data = o_wb_data;
  end
`endif

endmodule
